// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side consumer of the FIFO pointer controller.
// Pops one byte per frame with a single-cycle rd strobe, captures the
// synchronous RAM output and sends it as an 8N1 UART frame on tx.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  output logic              rd,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_next;
  logic              baud_last;

  // Registered state; tx idles high so an async reset truncates any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: fetch, load, then start/data/stop bits timed by the baud counter.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    shift_next = shift_q >> 1;
    baud_last  = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (enable && !empty) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = rd_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_next;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_next[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (enable && !empty) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign rd   = (state_q == FETCH);
  assign busy = (state_q != IDLE);
  assign tx   = tx_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer stage for the 4096-entry FIFO pointer controller.
- Watches the controller's empty flag and issues single-cycle rd pulses.
- Captures the byte returned by the synchronous FIFO RAM, which is addressed by r_addr.
- Serialises each byte as an 8N1 UART frame on tx, draining the FIFO back-to-back while enable is high.

Parameters:
- DATA_W, 8: data bits per frame and width of rd_data.
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Must be >= 2.
- CNT_W, 16: width of the baud counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames; sampled only in IDLE and at end of STOP.
- empty  input  1  FIFO empty flag from the pointer controller.
- rd  output  1  read strobe to the pointer controller; high exactly one cycle per byte.
- rd_data  input  DATA_W  synchronous RAM output; valid the cycle after rd.
- tx  output  1  UART serial line, idle high, registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On rst:
  - state=IDLE, tx=1, rd=0, busy=0.
  - Baud counter, bit counter and shift register cleared.
- States and transitions:
  - IDLE: tx=1. If enable && !empty, go to FETCH next edge; else stay.
  - FETCH: one cycle, rd=1. RAM captures mem[r_addr] and the controller increments r_ptr on this edge. Always go to LOAD.
  - LOAD: one cycle, shift_reg <= rd_data. tx <= 0 on the exiting edge. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx <= shift_reg[0].
  - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit. Bit counter runs 0..DATA_W-1. After the last bit, go to STOP with tx <= 1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its last cycle:
    - if enable && !empty, go to FETCH;
    - else go to IDLE.
- Signal rules:
  - rd is a decode of registered state (state==FETCH), so it is glitch-free and never high for two consecutive cycles.
  - rd is never asserted while empty=1.
  - Baud counter counts 0..CLKS_PER_BIT-1, resets to 0 on every state change, and wraps to 0 at CLKS_PER_BIT-1.
- Timing:
  - If empty falls while in IDLE at cycle N: FETCH at N+1, LOAD at N+2, tx low from N+3.
  - Frame length on tx is (DATA_W+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by 2 extra tx-high cycles (FETCH, LOAD), so the effective stop bit is CLKS_PER_BIT+2 cycles.
- Boundary conditions:
  - enable falling mid-frame: the current frame completes, then the block returns to IDLE.
  - enable is ignored outside IDLE and the last STOP cycle.
  - empty rising mid-frame: no effect on the frame in flight. This cannot happen from this block's own reads, because one rd consumes exactly one entry.
  - FIFO full: no special handling; the block only reads.
  - rst mid-frame: tx returns to 1 immediately and asynchronously. The frame is truncated. An entry already popped by rd is lost and not re-read.
  - rd_data is sampled only in LOAD; its value in any other cycle is ignored.

Test Plan:
- Reset: assert rst with empty=0 and enable=1 -> tx=1, rd=0, busy=0 while rst is high; first rd occurs 1 cycle after rst falls.
- Single byte, CLKS_PER_BIT=4: empty falls at cycle 10, rd_data=8'hA5 after rd -> rd high only at cycle 11. tx is low for cycles 13-16, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high from cycle 49. busy falls at cycle 53 if empty has returned to 1.
- Back-to-back: 3 entries 8'h00, 8'hFF, 8'h55, enable=1 -> three rd pulses spaced exactly (10*4+2)=42 cycles apart. Serial decode yields 00, FF, 55. No extra idle time between frames.
- enable drop: clear enable during the DATA phase of the first of 2 queued bytes -> first frame completes intact, block goes to IDLE, and rd is not pulsed again until enable returns high.
- Reset mid-frame: assert rst during the third data bit -> tx=1 in the same cycle, busy=0. After release with empty=0, the next entry is fetched and sent as a full frame.
- Empty guard: hold empty=1 for 1000 cycles with enable=1 -> rd stays 0, tx stays 1, busy stays 0 throughout.
